// File: rtl/change_dispenser.sv
// Change dispenser: pays out a latched amount largest-coin-first over a four-phase req/ack ejector handshake.
// Optional ack watchdog enabled by defining CHANGE_ACK_TIMEOUT_EN.
module change_dispenser #(
  parameter int AMT_W  = 8,
  parameter int CNT_W  = 6,
  parameter int ACK_TO = 255
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             q_empty,
  input  logic             d_empty,
  input  logic             n_empty,
  input  logic             eject_ack,
  input  logic             fault_clr,
  output logic             eject_req,
  output logic [1:0]       eject_coin,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] coins_out
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_REQ      = 3'd2,
    S_WAIT_LOW = 3'd3,
    S_DONE     = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  localparam logic [1:0] COIN_N = 2'b00;
  localparam logic [1:0] COIN_D = 2'b01;
  localparam logic [1:0] COIN_Q = 2'b10;

  localparam logic [AMT_W-1:0] VAL_N = AMT_W'(5'd5);
  localparam logic [AMT_W-1:0] VAL_D = AMT_W'(5'd10);
  localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(5'd25);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] coin);
    logic [AMT_W-1:0] val;
    case (coin)
      COIN_N:  val = VAL_N;
      COIN_D:  val = VAL_D;
      COIN_Q:  val = VAL_Q;
      default: val = {AMT_W{1'b0}};
    endcase
    return val;
  endfunction

  state_t           state_r, state_s;
  logic             eject_req_r, eject_req_s;
  logic [1:0]       coin_r, coin_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             fault_r, fault_s;
  logic [AMT_W-1:0] rem_r, rem_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             tmo_hit_s;

`ifdef CHANGE_ACK_TIMEOUT_EN
  localparam int TMO_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TO - 1);

  logic [TMO_W-1:0] tmo_r, tmo_s;

  assign tmo_hit_s = (tmo_r == TMO_LAST);

  // Watchdog count: runs while parked in REQ/WAIT_LOW, restarts on every state entry
  always_comb begin
    tmo_s = {TMO_W{1'b0}};
    if ((state_s == state_r) && ((state_r == S_REQ) || (state_r == S_WAIT_LOW))) begin
      tmo_s = tmo_r + TMO_W'(1'b1);
    end else begin
      tmo_s = {TMO_W{1'b0}};
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tmo_r <= {TMO_W{1'b0}};
    end else begin
      tmo_r <= tmo_s;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and next-output logic for the dispense sequencer
  always_comb begin
    state_s     = state_r;
    eject_req_s = eject_req_r;
    coin_s      = coin_r;
    fault_s     = fault_r;
    rem_s       = rem_r;
    cnt_s       = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          rem_s   = change_amt;
          cnt_s   = {CNT_W{1'b0}};
          state_s = S_SELECT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SELECT: begin
        // Tube flags are only looked at here; a coin in flight is never aborted
        if (rem_r == {AMT_W{1'b0}}) begin
          state_s = S_DONE;
        end else if ((rem_r >= VAL_Q) && !q_empty) begin
          coin_s      = COIN_Q;
          eject_req_s = 1'b1;
          state_s     = S_REQ;
        end else if ((rem_r >= VAL_D) && !d_empty) begin
          coin_s      = COIN_D;
          eject_req_s = 1'b1;
          state_s     = S_REQ;
        end else if ((rem_r >= VAL_N) && !n_empty) begin
          coin_s      = COIN_N;
          eject_req_s = 1'b1;
          state_s     = S_REQ;
        end else begin
          fault_s = 1'b1;
          state_s = S_FAULT;
        end
      end
      S_REQ: begin
        if (eject_ack) begin
          rem_s       = rem_r - coin_value(coin_r);
          cnt_s       = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1'b1);
          eject_req_s = 1'b0;
          state_s     = S_WAIT_LOW;
        end else if (tmo_hit_s) begin
          eject_req_s = 1'b0;
          fault_s     = 1'b1;
          state_s     = S_FAULT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT_LOW: begin
        if (!eject_ack) begin
          state_s = S_SELECT;
        end else if (tmo_hit_s) begin
          fault_s = 1'b1;
          state_s = S_FAULT;
        end else begin
          state_s = S_WAIT_LOW;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) begin
          fault_s = 1'b0;
          rem_s   = {AMT_W{1'b0}};
          state_s = S_IDLE;
        end else begin
          state_s = S_FAULT;
        end
      end
      default: begin
        eject_req_s = 1'b0;
        fault_s     = 1'b0;
        state_s     = S_IDLE;
      end
    endcase
    busy_s = (state_s != S_IDLE);
    done_s = (state_s == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r     <= S_IDLE;
      eject_req_r <= 1'b0;
      coin_r      <= 2'b00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
      rem_r       <= {AMT_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      eject_req_r <= eject_req_s;
      coin_r      <= coin_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      fault_r     <= fault_s;
      rem_r       <= rem_s;
      cnt_r       <= cnt_s;
    end
  end

  assign eject_req  = eject_req_r;
  assign eject_coin = coin_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign fault      = fault_r;
  assign remaining  = rem_r;
  assign coins_out  = cnt_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table of payouts plus hand-written reset/ignore sequences.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       start;
  logic [7:0] change_amt;
  logic       q_empty, d_empty, n_empty;
  logic       eject_ack;
  logic       fault_clr;
  logic       eject_req;
  logic [1:0] eject_coin;
  logic       busy, done, fault;
  logic [7:0] remaining;
  logic [5:0] coins_out;

  int errors = 0;
  int checks = 0;

  change_dispenser #(.AMT_W(8), .CNT_W(6), .ACK_TO(255)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .change_amt(change_amt),
    .q_empty(q_empty), .d_empty(d_empty), .n_empty(n_empty),
    .eject_ack(eject_ack), .fault_clr(fault_clr),
    .eject_req(eject_req), .eject_coin(eject_coin), .busy(busy), .done(done),
    .fault(fault), .remaining(remaining), .coins_out(coins_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] amt;
    logic       qe, de, ne;
    string      seq;   // expected coins in order: Q, D, N
    logic [7:0] rem;
    logic       flt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] code_of(input byte c);
    case (c)
      "Q":     return 2'b10;
      "D":     return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // one clock with an ejector that mirrors req right after the edge
  task automatic step_resp();
    @(posedge clk); #1;
    eject_ack = eject_req;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [1:0] got[$];
    logic       prev_req;
    bit         finished;
    int         ndone;
    string      tag;
    tag = $sformatf("v%0d_amt%0d", idx, v.amt);
    q_empty = v.qe; d_empty = v.de; n_empty = v.ne;
    change_amt = v.amt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; change_amt = 8'd0;
    chk({tag, "_busy_after_start"}, busy, 1);
    prev_req = 1'b0; finished = 1'b0; ndone = 0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (eject_req && !prev_req) got.push_back(eject_coin);
      prev_req = eject_req;
      if (done) ndone++;
      if (done || fault) begin
        finished = 1'b1;
      end else begin
        eject_ack = eject_req;
        @(posedge clk); #1;
      end
    end
    chk({tag, "_finished"}, finished, 1);
    chk({tag, "_ncoins"}, got.size(), v.seq.len());
    for (int i = 0; i < got.size() && i < v.seq.len(); i++)
      chk($sformatf("%s_coin%0d", tag, i), got[i], code_of(v.seq[i]));
    chk({tag, "_coins_out"}, coins_out, v.seq.len());
    chk({tag, "_remaining"}, remaining, v.rem);
    chk({tag, "_fault"}, fault, v.flt);
    chk({tag, "_done"}, ndone, v.flt ? 0 : 1);
    chk({tag, "_req_low"}, eject_req, 0);
    @(posedge clk); #1;
    if (v.flt) begin
      chk({tag, "_fault_sticky"}, fault, 1);
      chk({tag, "_busy_fault"}, busy, 1);
      fault_clr = 1'b1;
      @(posedge clk); #1;
      fault_clr = 1'b0;
      chk({tag, "_fault_cleared"}, fault, 0);
      chk({tag, "_rem_cleared"}, remaining, 0);
      chk({tag, "_coins_hold"}, coins_out, v.seq.len());
    end else begin
      chk({tag, "_done_one_cycle"}, done, 0);
    end
    chk({tag, "_idle"}, busy, 0);
    q_empty = 1'b0; d_empty = 1'b0; n_empty = 1'b0;
  endtask

  initial begin
    bit seen;
    clr_n = 1'b0; start = 1'b0; change_amt = 8'd0;
    q_empty = 1'b0; d_empty = 1'b0; n_empty = 1'b0;
    eject_ack = 1'b0; fault_clr = 1'b0;

    vecs[0] = '{8'd40,  1'b0, 1'b0, 1'b0, "QDN",         8'd0, 1'b0};
    vecs[1] = '{8'd30,  1'b1, 1'b0, 1'b0, "DDD",         8'd0, 1'b0};
    vecs[2] = '{8'd17,  1'b0, 1'b0, 1'b0, "DN",          8'd2, 1'b1};
    vecs[3] = '{8'd0,   1'b0, 1'b0, 1'b0, "",            8'd0, 1'b0};
    vecs[4] = '{8'd65,  1'b0, 1'b0, 1'b0, "QQDN",        8'd0, 1'b0};
    vecs[5] = '{8'd4,   1'b0, 1'b0, 1'b0, "",            8'd4, 1'b1};
    vecs[6] = '{8'd30,  1'b0, 1'b1, 1'b0, "QN",          8'd0, 1'b0};
    vecs[7] = '{8'd15,  1'b0, 1'b0, 1'b1, "D",           8'd5, 1'b1};
    vecs[8] = '{8'd255, 1'b0, 1'b0, 1'b0, "QQQQQQQQQQN", 8'd0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", eject_req, 0);
    chk("rst_coin", eject_coin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_coins_out", coins_out, 0);
    clr_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // zero amount: SELECT then DONE, pulse two cycles after start
    change_amt = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_no_done_yet", done, 0);
    @(posedge clk); #1;
    chk("zero_done_cycle2", done, 1);
    chk("zero_no_req", eject_req, 0);
    @(posedge clk); #1;
    chk("zero_idle", busy, 0);

    // start with 99 while dispensing 40 is ignored
    change_amt = 8'd40; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    step_resp();
    chk("mid_req_up", eject_req, 1);
    chk("mid_coin_q", eject_coin, 2);
    change_amt = 8'd99; start = 1'b1;
    step_resp();
    start = 1'b0; change_amt = 8'd0;
    chk("mid_rem_15", remaining, 15);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      step_resp();
      if (done) seen = 1'b1;
    end
    chk("mid_done_seen", seen, 1);
    chk("mid_rem_0", remaining, 0);
    chk("mid_coins_3", coins_out, 3);
    @(posedge clk); #1;
    chk("mid_idle", busy, 0);

    // async reset while a request is outstanding
    change_amt = 8'd40; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("rst2_req_up", eject_req, 1);
    #2 clr_n = 1'b0;
    #1;
    chk("rst2_req", eject_req, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_remaining", remaining, 0);
    chk("rst2_coin", eject_coin, 0);
    chk("rst2_coins_out", coins_out, 0);
    eject_ack = 1'b0;
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(posedge clk); #1;
    chk("rst2_still_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
